// File: rtl/st_width_downsizer_if.sv
// Avalon-ST signal bundle for the width downsizer: wide sink side plus narrow source side.
// slave is the adapter's view, master is the view of the logic around it.
interface st_width_downsizer_if #(
  parameter int SINK_WIDTH   = 16,
  parameter int SOURCE_WIDTH = 4
);
  localparam int RATIO       = SINK_WIDTH / SOURCE_WIDTH;
  localparam int EMPTY_WIDTH = (RATIO >= 2) ? $clog2(RATIO) : 1;

  logic                    st_sink_valid;
  logic                    st_sink_ready;
  logic [SINK_WIDTH-1:0]   st_sink_data;
  logic                    st_sink_startofpacket;
  logic                    st_sink_endofpacket;
  logic [EMPTY_WIDTH-1:0]  st_sink_empty;

  logic                    st_source_valid;
  logic                    st_source_ready;
  logic [SOURCE_WIDTH-1:0] st_source_data;
  logic                    st_source_startofpacket;
  logic                    st_source_endofpacket;

  modport slave (
    input  st_sink_valid, st_sink_data, st_sink_startofpacket,
           st_sink_endofpacket, st_sink_empty, st_source_ready,
    output st_sink_ready, st_source_valid, st_source_data,
           st_source_startofpacket, st_source_endofpacket
  );

  modport master (
    output st_sink_valid, st_sink_data, st_sink_startofpacket,
           st_sink_endofpacket, st_sink_empty, st_source_ready,
    input  st_sink_ready, st_source_valid, st_source_data,
           st_source_startofpacket, st_source_endofpacket
  );
endinterface

// File: rtl/st_width_downsizer.sv
// Avalon-ST width narrowing adapter: one wide word in, RATIO narrow beats out,
// with selectable symbol order, partial final words via empty, and no bubbles.
module st_width_downsizer #(
  parameter int SINK_WIDTH   = 16,
  parameter int SOURCE_WIDTH = 4,
  parameter bit MSB_FIRST    = 1'b0
) (
  input logic               clk,
  input logic               reset,
  st_width_downsizer_if.slave st
);
  localparam int RATIO       = SINK_WIDTH / SOURCE_WIDTH;
  localparam int EMPTY_WIDTH = (RATIO >= 2) ? $clog2(RATIO) : 1;
  localparam int IDX_W       = EMPTY_WIDTH;

  if ((SINK_WIDTH % SOURCE_WIDTH) != 0 || RATIO < 2) begin : g_param_check
    $error("st_width_downsizer: SINK_WIDTH must be a multiple of SOURCE_WIDTH with ratio >= 2");
  end

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [SINK_WIDTH-1:0]  word_q, word_d;
  logic                   sop_q, sop_d;
  logic                   eop_q, eop_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [IDX_W-1:0]       idx_q, idx_d;

  logic                   hold;
  logic                   at_last;
  logic                   sink_ready;
  logic                   load;
  logic [IDX_W-1:0]       sym_sel;
  logic [SOURCE_WIDTH-1:0] sym_arr [RATIO];

  // Index of the final beat; an out-of-range empty collapses the word to one beat.
  function automatic logic [IDX_W-1:0] last_of(input logic eop,
                                               input logic [EMPTY_WIDTH-1:0] empty);
    if (!eop) begin
      return IDX_W'(RATIO - 1);
    end else if (int'(empty) >= RATIO) begin
      return '0;
    end else begin
      return IDX_W'(RATIO - 1 - int'(empty));
    end
  endfunction

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_sym
    assign sym_arr[gi] = word_q[gi*SOURCE_WIDTH +: SOURCE_WIDTH];
  end

  if (MSB_FIRST) begin : g_msb_first
    assign sym_sel = IDX_W'(RATIO - 1) - idx_q;
  end else begin : g_lsb_first
    assign sym_sel = idx_q;
  end

  assign hold       = (state_q == HOLD) && !reset;
  assign at_last    = (idx_q == last_q);
  assign sink_ready = !reset && ((state_q == IDLE) || (at_last && st.st_source_ready));
  assign load       = st.st_sink_valid && sink_ready;

  assign st.st_sink_ready           = sink_ready;
  assign st.st_source_valid         = hold;
  assign st.st_source_data          = hold ? sym_arr[sym_sel] : '0;
  assign st.st_source_startofpacket = hold && sop_q && (idx_q == '0);
  assign st.st_source_endofpacket   = hold && eop_q && at_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      last_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
    end
  end

  // A load on the final beat chains the next word in with no idle cycle.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    last_d  = last_q;
    idx_d   = idx_q;
    if (load) begin
      state_d = HOLD;
      word_d  = st.st_sink_data;
      sop_d   = st.st_sink_startofpacket;
      eop_d   = st.st_sink_endofpacket;
      last_d  = last_of(st.st_sink_endofpacket, st.st_sink_empty);
      idx_d   = '0;
    end else if (state_q == HOLD && st.st_source_ready) begin
      if (!at_last) begin
        idx_d = idx_q + IDX_W'(1);
      end else begin
        state_d = IDLE;
      end
    end
  end
endmodule

// File: doc/st_width_downsizer.md
# st_width_downsizer

Parametrised Avalon-ST width narrowing adapter. It accepts one SINK_WIDTH word per handshake and emits it as RATIO = SINK_WIDTH/SOURCE_WIDTH consecutive SOURCE_WIDTH beats. It adds three things: selectable symbol order, an `empty` field for packets that end on a partial word, and full throughput with no bubble between words. It sits between wide memory/DMA read streams and narrow pixel/serialiser pipelines in the video path.

## Interface
- SINK_WIDTH, 16, sink data width in bits.
- SOURCE_WIDTH, 4, source data width in bits. SINK_WIDTH must be an integer multiple of SOURCE_WIDTH with RATIO ≥ 2; any other value raises `$error` at elaboration.
- MSB_FIRST, 0, beat order:
  - 0 = least-significant symbol first.
  - 1 = most-significant symbol first.
- EMPTY_WIDTH, derived as $clog2(RATIO); not overridable.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- st_sink_valid  in  1  sink word valid.
- st_sink_ready  out  1  sink may accept a word this cycle.
- st_sink_data  in  SINK_WIDTH  sink word.
- st_sink_startofpacket  in  1  first word of packet.
- st_sink_endofpacket  in  1  last word of packet.
- st_sink_empty  in  EMPTY_WIDTH  number of unused SOURCE_WIDTH symbols in the eop word; ignored (treated as 0) when eop is 0.
- st_source_valid  out  1  source beat valid.
- st_source_ready  in  1  downstream accepts beat.
- st_source_data  out  SOURCE_WIDTH  source beat.
- st_source_startofpacket  out  1  first beat of packet.
- st_source_endofpacket  out  1  last beat of packet.

## Operation
- **Storage:**
  - One holding register: word, sop, eop, last index L.
  - Beat counter `idx`, 0..RATIO-1.
- **Two states:**
  - IDLE: nothing held.
  - HOLD: word held, beats pending.
- **IDLE:**
  - st_sink_ready = 1 (except during reset).
  - On sink handshake: latch the word, set idx = 0, set L = RATIO-1-empty (L = RATIO-1 if eop = 0), go to HOLD.
- **HOLD:**
  - st_source_valid = 1.
  - The beat at `idx` is symbol idx when MSB_FIRST = 0, and symbol RATIO-1-idx when MSB_FIRST = 1.
  - Symbol k is data[k*SOURCE_WIDTH +: SOURCE_WIDTH].
- **Unused symbols with empty:**
  - MSB_FIRST = 0: the unused symbols are the high ones.
  - MSB_FIRST = 1: the unused symbols are the low ones.
  - In both cases the beats emitted are exactly the first L+1 in emission order.
- **Source handshake with idx < L:** idx increments.
- **Source handshake with idx == L:**
  - If st_sink_valid is also 1, the next word loads in the same cycle, idx = 0, and the block stays in HOLD.
  - Otherwise the block goes to IDLE.
- **st_sink_ready** = IDLE OR (HOLD AND idx == L AND st_source_ready). It is combinational from st_source_ready.
- **Packet flags:**
  - st_source_startofpacket = held sop AND idx == 0.
  - st_source_endofpacket = held eop AND idx == L.
- **Out-of-range empty:** empty ≥ RATIO is illegal and clamps to L = 0 (single beat).
- **Reset:**
  - Applies at any point, including mid-word; drops the held word.
  - State goes to IDLE, idx = 0.
  - Outputs: st_source_valid 0, st_source_data 0, sop 0, eop 0, st_sink_ready 0 while reset is high.

## Timing
- Latency: a sink handshake at edge N gives st_source_valid = 1 with beat 0 after edge N.
- All st_source_* outputs derive from registers and never depend combinationally on st_source_ready or st_sink_*.
- Throughput: with st_source_ready held high and the sink always valid, one beat per cycle and no idle cycle between words. A full-width stream runs at exactly RATIO cycles per sink word.
- Back-pressure: while st_source_ready = 0, data, sop and eop stay stable and idx does not advance.
- Sink data, sop, eop and empty are sampled only on a sink handshake.

## Test plan
- **LSB-first order:** defaults, word 16'hCBA1 with sop, ready always 1 -> beats 1,A,B,C on 4 consecutive cycles; sop on beat 1 only; eop never.
- **MSB-first order:** MSB_FIRST = 1, same word -> beats C,B,A,1.
- **Partial final word:** packet 16'hCBA1 (sop), then 16'hCBA2 (eop, empty = 2), LSB-first -> beats 1,A,B,C,2,A; eop only on the final A; 6 beats total, nothing after. MSB_FIRST = 1 with the same packet -> C,B,A,1,C,B with eop on the final B.
- **Full throughput:** 8 words 16'hCBA1..16'hCBA8 presented back-to-back with both readies high -> 32 beats in 32 consecutive cycles; st_sink_ready pulses on every 4th beat.
- **Random back-pressure:** st_source_ready deasserted with 30% probability, sink valid randomly dropped -> beat sequence identical to the full-throughput case; outputs stable while stalled; no beat lost or duplicated.
- **Reset mid-word:** reset after beat 2 of 16'hCBA1 -> valid drops the next cycle. After release, 16'h1234 yields 4,3,2,1 with sop on 4 and no residue of the dropped word.
